cache_mem_arbiter: RTL and testbench

Arbitrates line-sized miss traffic from the instruction cache and the data cache onto the single physical-memory burst port. Sits between the two L1 caches that feed the pipelined datapath's `instr_mem_*` and `data_mem_*` interfaces, and the cacheline adaptor. It serialises one transaction at a time, latches the winner's address and data, and returns a single-cycle response to the granted cache only.

---
 rtl/cache_mem_arbiter_if.sv | 46 ++++
 rtl/cache_mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_arbiter_if.sv
// Bundle of the I-cache, D-cache and physical-memory signals seen by cache_mem_arbiter.
// The slave modport is the arbiter's view and the master modport is the caches plus memory.
interface cache_mem_arbiter_if #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
);
  // I-cache side
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  // D-cache side
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  // Physical memory burst port
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_addr;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  i_read, i_addr,
    output i_rdata, i_resp,
    input  d_read, d_write, d_addr, d_wdata,
    output d_rdata, d_resp,
    output pmem_read, pmem_write, pmem_addr, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output i_read, i_addr,
    input  i_rdata, i_resp,
    output d_read, d_write, d_addr, d_wdata,
    input  d_rdata, d_resp,
    input  pmem_read, pmem_write, pmem_addr, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Serialises I-cache fills and D-cache fills/writebacks onto one line-wide memory port.
// Define ARB_ROUND_ROBIN_EN for alternating tie-break; otherwise the D-cache wins ties.
module cache_mem_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  cache_mem_arbiter_if.slave arb_if
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  logic              we_q, we_d;
  logic              pmem_read_q, pmem_read_d;
  logic              pmem_write_q, pmem_write_d;
  logic              i_resp_q, i_resp_d;
  logic              d_resp_q, d_resp_d;

  logic req_i;
  logic req_d;
  logic d_wins_tie;
  logic pick_d;

  assign req_i = arb_if.i_read;
  assign req_d = arb_if.d_read | arb_if.d_write;

`ifdef ARB_ROUND_ROBIN_EN
  owner_e last_q, last_d;
  assign d_wins_tie = (last_q == OWN_I);
`else
  assign d_wins_tie = 1'b1;
`endif

  assign pick_d = req_d & (~req_i | d_wins_tie);

  // NOTE: every signal driven here gets a default first, so no branch can infer a latch.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    we_d         = we_q;
    pmem_read_d  = pmem_read_q;
    pmem_write_d = pmem_write_q;
    i_resp_d     = 1'b0;
    d_resp_d     = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_d       = last_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (req_i || req_d) begin
          if (pick_d) begin
            // A simultaneous d_read/d_write becomes a writeback; the cache re-presents the read.
            state_d      = BUSY_D;
            owner_d      = OWN_D;
            addr_d       = arb_if.d_addr;
            wdata_d      = arb_if.d_wdata;
            we_d         = arb_if.d_write;
            pmem_read_d  = ~arb_if.d_write;
            pmem_write_d = arb_if.d_write;
          end else begin
            state_d      = BUSY_I;
            owner_d      = OWN_I;
            addr_d       = arb_if.i_addr;
            we_d         = 1'b0;
            pmem_read_d  = 1'b1;
            pmem_write_d = 1'b0;
          end
`ifdef ARB_ROUND_ROBIN_EN
          last_d = pick_d ? OWN_D : OWN_I;
`endif
        end
      end

      BUSY_I, BUSY_D: begin
        if (arb_if.pmem_resp) begin
          state_d      = DONE;
          rdata_d      = arb_if.pmem_rdata;
          pmem_read_d  = 1'b0;
          pmem_write_d = 1'b0;
          i_resp_d     = (owner_q == OWN_I);
          d_resp_d     = (owner_q == OWN_D);
        end
      end

      // One dead cycle lets the owner drop its request before IDLE samples again.
      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments, so every register samples pre-edge values regardless of order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_I;
      // NOTE: the line holders are flops, not a RAM array, so they take the async reset and
      // the rdata/wdata outputs read as zero straight out of reset.
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      we_q         <= 1'b0;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
      i_resp_q     <= 1'b0;
      d_resp_q     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q       <= OWN_D;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      we_q         <= we_d;
      pmem_read_q  <= pmem_read_d;
      pmem_write_q <= pmem_write_d;
      i_resp_q     <= i_resp_d;
      d_resp_q     <= d_resp_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q       <= last_d;
`endif
    end
  end

  assign arb_if.pmem_read  = pmem_read_q;
  assign arb_if.pmem_write = pmem_write_q;
  assign arb_if.pmem_addr  = addr_q;
  assign arb_if.pmem_wdata = wdata_q;
  assign arb_if.i_rdata    = rdata_q;
  assign arb_if.d_rdata    = rdata_q;
  assign arb_if.i_resp     = i_resp_q;
  assign arb_if.d_resp     = d_resp_q;

  a_one_strobe : assert property (@(posedge clk) disable iff (!rst)
    !(pmem_read_q && pmem_write_q));
  a_one_resp   : assert property (@(posedge clk) disable iff (!rst)
    !(i_resp_q && d_resp_q));
  a_i_pulse    : assert property (@(posedge clk) disable iff (!rst)
    i_resp_q |=> !i_resp_q);
  a_d_pulse    : assert property (@(posedge clk) disable iff (!rst)
    d_resp_q |=> !d_resp_q);
  a_we_strobe  : assert property (@(posedge clk) disable iff (!rst)
    pmem_write_q |-> we_q);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed vectors, corner sequences, and a
// randomized phase against a line-level memory model with arbitration rules.
module tb_cache_mem_arbiter;
  localparam int LW         = 256;
  localparam int AW         = 32;
  localparam int RND_CYCLES = 3000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_mem_arbiter_if #(.LINE_W(LW), .ADDR_W(AW)) bus ();
  cache_mem_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .arb_if(bus));

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit            use_d;
    bit            rd;
    bit            wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    int            lat;
    logic [LW-1:0] mdata;
    bit            exp_we;
  } vec_t;

  vec_t vecs [5];

  // Randomized-phase model state
  logic [LW-1:0] ref_mem [bit [AW-1:0]];
  logic [LW-1:0] phy_mem [bit [AW-1:0]];
  bit            i_busy, d_busy, d_rd, d_wr;
  logic [AW-1:0] i_a, d_a;
  logic [LW-1:0] d_w;
  bit            active, act_d, act_we, resp_due, gap, tie_d, first_d;
  bit            last_d;
  logic [AW-1:0] act_addr;
  logic [LW-1:0] act_wdata;
  int            lat_left, op;
  logic          strobe;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] default_line(input logic [AW-1:0] a);
    return {8{a ^ 32'hC0DE_0000}};
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int j = 0; j < 8; j++) r[32*j +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [AW-1:0] pick_addr();
    return 32'h0000_1000 + (32'($urandom_range(0, 7)) << 5);
  endfunction

  function automatic logic [LW-1:0] ref_read(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : default_line(a);
  endfunction

  function automatic logic [LW-1:0] phy_read(input logic [AW-1:0] a);
    return phy_mem.exists(a) ? phy_mem[a] : default_line(a);
  endfunction

  task automatic clear_reqs();
    bus.i_read     = 1'b0;
    bus.i_addr     = '0;
    bus.d_read     = 1'b0;
    bus.d_write    = 1'b0;
    bus.d_addr     = '0;
    bus.d_wdata    = '0;
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
  endtask

  // Called at a negedge with the request already driven: expects the strobe one cycle later,
  // answers after lat busy cycles, checks the resp pulse and the following idle cycle.
  task automatic serve(input string tag, input bit exp_d, input bit exp_we,
                       input logic [AW-1:0] exp_addr, input logic [LW-1:0] exp_wdata,
                       input int lat, input logic [LW-1:0] rdata, input bit drop);
    int w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!(bus.pmem_read || bus.pmem_write) && w < 20);
    check({tag, "_grant_cycle"}, w, 1);
    check({tag, "_strobes"}, {bus.pmem_read, bus.pmem_write}, {~exp_we, exp_we});
    check({tag, "_addr"}, bus.pmem_addr, exp_addr);
    if (exp_we) check({tag, "_wdata"}, bus.pmem_wdata, exp_wdata);
    for (int k = 1; k < lat; k++) begin
      @(negedge clk);
      check({tag, "_hold"}, {bus.pmem_read, bus.pmem_write, bus.pmem_addr},
            {~exp_we, exp_we, exp_addr});
    end
    bus.pmem_rdata = rdata;
    bus.pmem_resp  = 1'b1;
    @(negedge clk);
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    check({tag, "_resp"}, {bus.i_resp, bus.d_resp}, {~exp_d, exp_d});
    check({tag, "_strobe_drop"}, {bus.pmem_read, bus.pmem_write}, 2'b00);
    if (!exp_we) check({tag, "_rdata"}, exp_d ? bus.d_rdata : bus.i_rdata, rdata);
    if (drop) begin
      if (exp_d) begin
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
      end else begin
        bus.i_read = 1'b0;
      end
    end
    @(negedge clk);
    check({tag, "_idle"}, {bus.i_resp, bus.d_resp, bus.pmem_read, bus.pmem_write}, 4'b0000);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{use_d: 1'b0, rd: 1'b1, wr: 1'b0, addr: 32'h0000_1000, wdata: '0,
                lat: 4, mdata: {32{8'hAA}}, exp_we: 1'b0};
    vecs[1] = '{use_d: 1'b1, rd: 1'b0, wr: 1'b1, addr: 32'h0000_2000, wdata: {32{8'h55}},
                lat: 2, mdata: {8{32'h1234_5678}}, exp_we: 1'b1};
    vecs[2] = '{use_d: 1'b1, rd: 1'b1, wr: 1'b0, addr: 32'h0000_3000, wdata: '0,
                lat: 1, mdata: {8{32'hDEAD_BEEF}}, exp_we: 1'b0};
    vecs[3] = '{use_d: 1'b1, rd: 1'b1, wr: 1'b1, addr: 32'h0000_4000, wdata: {8{32'h0F0F_1234}},
                lat: 3, mdata: {8{32'h9999_0000}}, exp_we: 1'b1};
    vecs[4] = '{use_d: 1'b0, rd: 1'b1, wr: 1'b0, addr: 32'hFFFF_FFE0, wdata: '0,
                lat: 1, mdata: {16{16'hC3A5}}, exp_we: 1'b0};

    clear_reqs();
    #1 rst = 1'b0;
    #1;
    check("reset_strobes", {bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp}, 4'b0000);
    check("reset_pmem_addr", bus.pmem_addr, '0);
    check("reset_pmem_wdata", bus.pmem_wdata, '0);
    check("reset_i_rdata", bus.i_rdata, '0);
    check("reset_d_rdata", bus.d_rdata, '0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Simultaneous requests straight after reset, both held until served
`ifdef ARB_ROUND_ROBIN_EN
    first_d = 1'b0;
`else
    first_d = 1'b1;
`endif
    bus.i_read = 1'b1;
    bus.i_addr = 32'h0000_1100;
    bus.d_read = 1'b1;
    bus.d_addr = 32'h0000_2200;
    serve("tie_first", first_d, 1'b0, first_d ? 32'h0000_2200 : 32'h0000_1100, '0, 2,
          first_d ? {8{32'hD0D0_0001}} : {8{32'h1010_0001}}, 1'b1);
    serve("tie_second", ~first_d, 1'b0, first_d ? 32'h0000_1100 : 32'h0000_2200, '0, 1,
          first_d ? {8{32'h1010_0002}} : {8{32'hD0D0_0002}}, 1'b1);

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].use_d) begin
        bus.d_read  = vecs[i].rd;
        bus.d_write = vecs[i].wr;
        bus.d_addr  = vecs[i].addr;
        bus.d_wdata = vecs[i].wdata;
      end else begin
        bus.i_read = vecs[i].rd;
        bus.i_addr = vecs[i].addr;
      end
      serve($sformatf("vec%0d", i), vecs[i].use_d, vecs[i].exp_we, vecs[i].addr,
            vecs[i].wdata, vecs[i].lat, vecs[i].mdata, 1'b1);
    end

    // Read+write together: write first, read only once re-presented alone
    bus.d_read  = 1'b1;
    bus.d_write = 1'b1;
    bus.d_addr  = 32'h0000_4400;
    bus.d_wdata = {8{32'hA1B2_C3D4}};
    serve("rw_write", 1'b1, 1'b1, 32'h0000_4400, {8{32'hA1B2_C3D4}}, 2, '0, 1'b0);
    bus.d_write = 1'b0;
    serve("rw_reread", 1'b1, 1'b0, 32'h0000_4400, '0, 1, {8{32'hA1B2_C3D4}}, 1'b1);

    // I request held through DONE: regranted only from IDLE, one resp per memory resp
    bus.i_read = 1'b1;
    bus.i_addr = 32'h0000_5500;
    serve("slow_drop_a", 1'b0, 1'b0, 32'h0000_5500, '0, 1, {8{32'h5A5A_0001}}, 1'b0);
    serve("slow_drop_b", 1'b0, 1'b0, 32'h0000_5500, '0, 2, {8{32'h5A5A_0002}}, 1'b1);

    // Async reset during BUSY_D, then a stale memory response
    bus.d_write = 1'b1;
    bus.d_addr  = 32'h0000_6600;
    bus.d_wdata = {LW{1'b1}};
    @(negedge clk);
    check("rst_busy_write", bus.pmem_write, 1'b1);
    #2 rst = 1'b0;
    clear_reqs();
    #1;
    check("rst_async_strobes", {bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp}, 4'b0000);
    check("rst_async_addr", bus.pmem_addr, '0);
    check("rst_async_wdata", bus.pmem_wdata, '0);
    check("rst_async_rdata", {bus.i_rdata, bus.d_rdata}, '0);
    #1 rst = 1'b1;
    @(negedge clk);
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = {LW{1'b1}};
    @(negedge clk);
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    check("rst_late_resp", {bus.i_resp, bus.d_resp, bus.pmem_read, bus.pmem_write}, 4'b0000);
    check("rst_late_rdata", bus.d_rdata, '0);

    // Randomized traffic; last owner after reset is D
    i_busy   = 1'b0;
    d_busy   = 1'b0;
    active   = 1'b0;
    resp_due = 1'b0;
    gap      = 1'b0;
    last_d   = 1'b1;
    for (int cyc = 0; cyc < RND_CYCLES + 40; cyc++) begin
      @(negedge clk);
      strobe = bus.pmem_read | bus.pmem_write;
      if (resp_due) begin
        check("rnd_resp", {bus.i_resp, bus.d_resp}, {~act_d, act_d});
        check("rnd_resp_strobe", strobe, 1'b0);
        if (act_we) ref_mem[act_addr] = act_wdata;
        else check("rnd_rdata", act_d ? bus.d_rdata : bus.i_rdata, ref_read(act_addr));
        if (act_d) d_busy = 1'b0;
        else       i_busy = 1'b0;
        active   = 1'b0;
        resp_due = 1'b0;
        gap      = 1'b1;
      end else begin
        check("rnd_no_resp", {bus.i_resp, bus.d_resp}, 2'b00);
        if (gap) begin
          check("rnd_gap", strobe, 1'b0);
          gap = 1'b0;
        end else if (!active && strobe) begin
          if (!i_busy && !d_busy) begin
            check("rnd_unrequested_grant", strobe, 1'b0);
          end else begin
`ifdef ARB_ROUND_ROBIN_EN
            tie_d = ~last_d;
`else
            tie_d = 1'b1;
`endif
            act_d     = d_busy && (!i_busy || tie_d);
            act_we    = act_d && d_wr;
            act_addr  = act_d ? d_a : i_a;
            act_wdata = d_w;
            last_d    = act_d;
            active    = 1'b1;
            lat_left  = $urandom_range(0, 3);
            check("rnd_grant_rw", {bus.pmem_read, bus.pmem_write}, {~act_we, act_we});
            check("rnd_grant_addr", bus.pmem_addr, act_addr);
            if (act_we) check("rnd_grant_wdata", bus.pmem_wdata, act_wdata);
          end
        end else if (active) begin
          check("rnd_hold", {bus.pmem_read, bus.pmem_write, bus.pmem_addr},
                {~act_we, act_we, act_addr});
        end
      end

      // Memory: answers the live strobe after a random wait, sometimes pulses resp while idle
      bus.pmem_resp = 1'b0;
      if (active) begin
        if (lat_left == 0) begin
          if (bus.pmem_write) begin
            phy_mem[bus.pmem_addr] = bus.pmem_wdata;
            bus.pmem_rdata = rand_line();
          end else begin
            bus.pmem_rdata = phy_read(bus.pmem_addr);
          end
          bus.pmem_resp = 1'b1;
          resp_due      = 1'b1;
        end else begin
          lat_left--;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = rand_line();
      end

      if (cyc < RND_CYCLES) begin
        if (!i_busy && $urandom_range(0, 3) == 0) begin
          i_busy = 1'b1;
          i_a    = pick_addr();
        end
        if (!d_busy && $urandom_range(0, 3) == 0) begin
          d_busy = 1'b1;
          d_a    = pick_addr();
          op     = $urandom_range(0, 2);
          d_rd   = (op != 1);
          d_wr   = (op != 0);
          d_w    = rand_line();
        end
      end
      bus.i_read  = i_busy;
      bus.i_addr  = i_a;
      bus.d_read  = d_busy && d_rd;
      bus.d_write = d_busy && d_wr;
      bus.d_addr  = d_a;
      bus.d_wdata = d_w;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
